// File: rtl/decode_scan.sv
// Registered binary-to-one-hot decoder with manual decode and prescaled auto-scan.
// Define DECODE_ACTIVE_LOW_EN to drive Y inverted (selected line low) for common-anode displays.
module decode_scan #(
  parameter int W        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        code,
  input  logic                en,
  input  logic                scan,
  output logic [(2**W)-1:0]   Y,
  output logic [W-1:0]        idx,
  output logic                valid
);

  localparam int N  = 2**W;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [N-1:0]  LINE0   = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_y, w_y_next;
  logic [W-1:0]   r_idx, w_idx_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic           r_valid, w_valid_next;
  logic [W-1:0]   w_idx_inc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_IDLE;
    if (scan)    w_state_next = S_SCAN;
    else if (en) w_state_next = S_MANUAL;
  end

  assign w_idx_inc = r_idx + W'(1);

  always_comb begin
    w_y_next     = '0;
    w_idx_next   = r_idx;
    w_cnt_next   = '0;
    w_valid_next = 1'b0;
    case (w_state_next)
      S_MANUAL: begin
        w_y_next     = LINE0 << code;
        w_idx_next   = code;
        w_valid_next = 1'b1;
      end
      S_SCAN: begin
        w_valid_next = 1'b1;
        if (r_state != S_SCAN) begin
          // Every scan request restarts at line 0; no resume from a previous scan.
          w_y_next   = LINE0;
          w_idx_next = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_y_next   = LINE0 << w_idx_inc;
          w_idx_next = w_idx_inc;
        end else begin
          w_y_next   = r_y;
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= w_y_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_valid_next;
    end
  end

`ifdef DECODE_ACTIVE_LOW_EN
  assign Y = ~r_y;
`else
  assign Y = r_y;
`endif
  assign idx   = r_idx;
  assign valid = r_valid;

endmodule
